ccff_bitstream_loader: RTL and testbench

//  Drives a tile configuration chain (ccff_head -> ... -> ccff_tail) from the programming side.
//  - Accepts bitstream words over a valid/ready stream.
//  - Serialises them MSB-first onto ccff_head, one bit per prog_clk, with ccff_shift_en gating the chain.
//  - Reports completion; optionally verifies the chain non-destructively by recirculation.

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_crc16_serial.sv | 25 ++
 rtl/ccff_bitstream_loader.sv | 163 ++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// rtl/ccff_loader_pkg.sv - shared state encoding and CRC-16/CCITT helper for the ccff loader
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        VERIFY,
        DONE
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One serial step of the MSB-first CCITT CRC.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        crc16_step = {crc[14:0], 1'b0} ^ (((crc[15] ^ b) == 1'b1) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// rtl/ccff_crc16_serial.sv - bit-serial CRC-16/CCITT accumulator with synchronous clear
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= crc16_step(r_crc, i_bit);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// rtl/ccff_bitstream_loader.sv - serialises bitstream words MSB-first into a configuration chain
// Optional recirculating CRC readback verify when CCFF_READBACK_VERIFY_EN is defined.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [CNT_W-1:0]  bits_shifted
);

    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WB_W-1:0]  FULL_WORD = WB_W'(WORD_W);

    state_e            r_state;
    state_e            w_next;
    logic [WORD_W-1:0] r_sreg;
    logic [WB_W-1:0]   r_wbits;
    logic [CNT_W-1:0]  r_bits;
    logic              w_start_ok;
    logic              w_last_bit;

    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last_bit = (r_bits == LAST_BIT);

`ifdef CCFF_READBACK_VERIFY_EN
    logic [CNT_W-1:0] r_vcnt;
    logic             r_error;
    logic [15:0]      w_crc_load;
    logic [15:0]      w_crc_tail;
    logic             w_verify_last;

    assign w_verify_last = (r_vcnt == LAST_BIT);

    ccff_crc16_serial u_crc_load (
        .i_clk   (prog_clk),
        .i_rst   (prog_reset),
        .i_clear (w_start_ok),
        .i_en    (r_state == SHIFT),
        .i_bit   (r_sreg[WORD_W-1]),
        .o_crc   (w_crc_load)
    );

    ccff_crc16_serial u_crc_tail (
        .i_clk   (prog_clk),
        .i_rst   (prog_reset),
        .i_clear (w_start_ok),
        .i_en    (r_state == VERIFY),
        .i_bit   (ccff_tail),
        .o_crc   (w_crc_tail)
    );

    // The final tail bit lands in the CRC on the same edge, so fold it in here.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_vcnt  <= '0;
            r_error <= 1'b0;
        end else if (w_start_ok) begin
            r_vcnt  <= '0;
            r_error <= 1'b0;
        end else if (r_state == VERIFY) begin
            r_vcnt <= r_vcnt + 1'b1;
            if (w_verify_last) begin
                r_error <= (w_crc_load != crc16_step(w_crc_tail, ccff_tail));
            end
        end
    end

    assign error = r_error;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign error         = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_wbits <= '0;
            r_bits  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_bits <= '0;
            end
            if ((r_state == LOAD) && word_valid) begin
                r_sreg  <= word_data;
                r_wbits <= FULL_WORD;
            end
            if (r_state == SHIFT) begin
                r_sreg  <= {r_sreg[WORD_W-2:0], 1'b0};
                r_wbits <= r_wbits - 1'b1;
                r_bits  <= r_bits + 1'b1;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        word_ready    = 1'b0;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) w_next = LOAD;
            end
            LOAD: begin
                word_ready = 1'b1;
                busy       = 1'b1;
                if (word_valid) w_next = SHIFT;
            end
            SHIFT: begin
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = r_sreg[WORD_W-1];
                if (w_last_bit) begin
`ifdef CCFF_READBACK_VERIFY_EN
                    w_next = VERIFY;
`else
                    w_next = DONE;
`endif
                end else if (r_wbits == WB_W'(1)) begin
                    w_next = LOAD;
                end
            end
            VERIFY: begin
`ifdef CCFF_READBACK_VERIFY_EN
                busy          = 1'b1;
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                if (w_verify_last) w_next = DONE;
`else
                w_next = IDLE;
`endif
            end
            DONE: begin
                done = 1'b1;
                if (start) w_next = LOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bits_shifted = r_bits;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// tb/tb_ccff_bitstream_loader.sv - self-checking bench for ccff_bitstream_loader with chain models
module tb_ccff_bitstream_loader;

`ifdef CCFF_READBACK_VERIFY_EN
    localparam int VEXTRA = 1;
`else
    localparam int VEXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start64 = 1'b0, start40 = 1'b0;
    logic        valid64 = 1'b0, valid40 = 1'b0;
    logic [31:0] wdata = '0;
    logic        ready64, ready40, head64, head40, sen64, sen40;
    logic        busy64, busy40, done64, done40, err64, err40;
    logic [6:0]  bits64;
    logic [5:0]  bits40;
    logic [63:0] ch64 = '0;
    logic [39:0] ch40 = '0;
    logic        flip_arm = 1'b0, flipped = 1'b0;
    logic        saw_ready;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(64)) u_dut64 (
        .prog_clk(clk), .prog_reset(rst), .start(start64), .word_valid(valid64),
        .word_data(wdata), .word_ready(ready64), .ccff_head(head64), .ccff_shift_en(sen64),
        .ccff_tail(ch64[63]), .busy(busy64), .done(done64), .error(err64), .bits_shifted(bits64)
    );

    ccff_bitstream_loader #(.WORD_W(32), .CHAIN_LEN(40)) u_dut40 (
        .prog_clk(clk), .prog_reset(rst), .start(start40), .word_valid(valid40),
        .word_data(wdata), .word_ready(ready40), .ccff_head(head40), .ccff_shift_en(sen40),
        .ccff_tail(ch40[39]), .busy(busy40), .done(done40), .error(err40), .bits_shifted(bits40)
    );

    // Chain models: plain shift registers clocked when shift_en is high.
    always @(posedge clk) begin
        logic [63:0] n;
        n = ch64;
        if (flip_arm && !flipped && busy64 && bits64 == 7'd64) begin
            n[5] = ~n[5];
            flipped <= 1'b1;
        end
        if (!flip_arm) flipped <= 1'b0;
        if (sen64) n = {n[62:0], head64};
        ch64 <= n;
        if (sen40) ch40 <= {ch40[38:0], head40};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(int sel); return sel == 0 ? ready64 : ready40; endfunction
    function automatic logic sen(int sel); return sel == 0 ? sen64 : sen40; endfunction
    function automatic logic dn(int sel);  return sel == 0 ? done64 : done40; endfunction
    function automatic logic er(int sel);  return sel == 0 ? err64 : err40; endfunction
    function automatic logic bz(int sel);  return sel == 0 ? busy64 : busy40; endfunction
    function automatic logic [63:0] bs(int sel);
        return sel == 0 ? 64'(bits64) : 64'(bits40);
    endfunction
    function automatic logic [63:0] chain(int sel);
        return sel == 0 ? ch64 : 64'(ch40);
    endfunction

    task automatic set_valid(int sel, logic v);
        if (sel == 0) valid64 = v; else valid40 = v;
    endtask

    // Expected chain image: k-th streamed bit ends at position len-1-k.
    function automatic logic [63:0] image(input logic [31:0] w[$], input int len);
        logic [63:0] img;
        logic [31:0] x;
        img = '0;
        for (int k = 0; k < len; k++) begin
            x = w[k / 32];
            img[len - 1 - k] = x[31 - (k % 32)];
        end
        return img;
    endfunction

    function automatic int latency(int len);
        return len + (len + 31) / 32 + 1 + VEXTRA * len;
    endfunction

    task automatic run_load(input int sel, input logic [31:0] w[$], input int gap, output int cycles);
        int t;
        cycles = 0;
        saw_ready = 1'b0;
        if (sel == 0) start64 = 1'b1; else start40 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0; start40 = 1'b0;
        cycles = 1;
        check("start_busy", bz(sel), 1'b1);
        check("start_err_clr", er(sel), 1'b0);
        for (int i = 0; i < w.size(); i++) begin
            if (i > 0 && gap > 0) begin
                t = 0;
                while (!rdy(sel) && t < 200) begin @(posedge clk); #1; cycles++; t++; end
                repeat (gap) begin
                    @(posedge clk); #1; cycles++;
                    check("stall_shift_en", sen(sel), 1'b0);
                end
            end
            wdata = w[i];
            set_valid(sel, 1'b1);
            t = 0;
            while (!rdy(sel) && t < 200) begin @(posedge clk); #1; cycles++; t++; end
            if (t >= 200) check("tmo_ready", rdy(sel), 1'b1);
            @(posedge clk); #1; cycles++;
            set_valid(sel, 1'b0);
        end
        t = 0;
        while (!dn(sel) && t < 2000) begin
            if (rdy(sel)) saw_ready = 1'b1;
            @(posedge clk); #1; cycles++; t++;
        end
        check("tmo_done", dn(sel), 1'b1);
    endtask

    initial begin
        logic [31:0] q[$];
        int          cyc, t, sel, len, gap;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready64", ready64, 0); check("rst_head64", head64, 0);
        check("rst_sen64", sen64, 0);     check("rst_busy64", busy64, 0);
        check("rst_done64", done64, 0);   check("rst_err64", err64, 0);
        check("rst_bits64", bits64, 0);   check("rst_bits40", bits40, 0);
        check("rst_busy40", busy40, 0);   check("rst_ready40", ready40, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        valid64 = 1'b1; wdata = 32'h1111_1111;
        repeat (3) begin @(posedge clk); #1; check("idle_no_ready", ready64, 0); end
        valid64 = 1'b0;

        q = '{32'hDEADBEEF, 32'h01234567};
        run_load(0, q, 0, cyc);
        check("t1_latency", cyc, latency(64));
        check("t1_chain", ch64, 64'hDEADBEEF_01234567);
        check("t1_bits", bits64, 64);
        check("t1_err", err64, 0);
        check("t1_busy", busy64, 0);
        check("t1_ready_after_last", saw_ready, 0);

        q = '{32'hFFFFFFFF, 32'hA5000000};
        run_load(1, q, 0, cyc);
        check("t2_latency", cyc, latency(40));
        check("t2_chain", ch40, 64'hFF_FFFF_FFA5);
        check("t2_bits", bits40, 40);
        check("t2_ready_after_last", saw_ready, 0);

        ch64 = '0;
        q = '{32'hDEADBEEF, 32'h01234567};
        run_load(0, q, 10, cyc);
        check("t3_chain", ch64, 64'hDEADBEEF_01234567);
        check("t3_bits", bits64, 64);

        start64 = 1'b1;
        @(posedge clk); #1;
        start64 = 1'b0;
        valid64 = 1'b1; wdata = 32'hCAFEF00D;
        t = 0;
        while (bits64 != 7'd20 && t < 200) begin @(posedge clk); #1; t++; end
        check("t4_reach20", bits64, 20);
        valid64 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t4_ready", ready64, 0); check("t4_head", head64, 0);
        check("t4_sen", sen64, 0);     check("t4_busy", busy64, 0);
        check("t4_done", done64, 0);   check("t4_err", err64, 0);
        check("t4_bits", bits64, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        q = '{32'h13579BDF, 32'h2468ACE0};
        run_load(0, q, 0, cyc);
        check("t4_reload_chain", ch64, 64'h13579BDF_2468ACE0);
        check("t4_reload_latency", cyc, latency(64));

`ifdef CCFF_READBACK_VERIFY_EN
        q = '{32'hDEADBEEF, 32'h01234567};
        flip_arm = 1'b1;
        run_load(0, q, 0, cyc);
        flip_arm = 1'b0;
        check("t6_error", err64, 1);
        check("t6_done", done64, 1);
        run_load(0, q, 0, cyc);
        check("t6_recover_err", err64, 0);
        check("t6_recover_chain", ch64, 64'hDEADBEEF_01234567);
`endif

        for (int it = 0; it < 10; it++) begin
            sel = int'($urandom_range(0, 1));
            len = (sel == 0) ? 64 : 40;
            gap = int'($urandom_range(0, 3));
            q = '{$urandom(), $urandom()};
            run_load(sel, q, gap, cyc);
            check("rnd_chain", chain(sel), image(q, len));
            check("rnd_bits", bs(sel), 64'(len));
            check("rnd_err", er(sel), 0);
            if (gap == 0) check("rnd_latency", cyc, latency(len));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
